// File: rtl/lvds_serializer_tx.sv
// Parallel-to-serial LVDS transmit path: one bit per clk, fixed-length slots that
// carry a training word, a data word from the valid/ready source, or an all-zero idle word.
module lvds_serializer_tx #(
  parameter int                    DATA_WIDTH    = 10,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 10'h3F0,
  parameter bit                    MSB_FIRST     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  train,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  sout,
  output logic                  frame_start,
  output logic                  word_is_data,
  output logic [15:0]           tx_word_cnt
);

  localparam int            CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_TRAIN,
    SLOT_DATA
  } slot_t;

  slot_t                 slot_reg, slot_next;
  logic [CW-1:0]         bit_cnt_reg, bit_cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  sout_reg, sout_next;
  logic                  frame_start_reg, frame_start_next;
  logic                  word_is_data_reg, word_is_data_next;
  logic [15:0]           tx_word_cnt_reg, tx_word_cnt_next;

  logic                  boundary;
  logic                  accept;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] load_rev;
  logic [DATA_WIDTH-1:0] load_ordered;
  logic [DATA_WIDTH-1:0] shift_src;

  assign boundary   = (bit_cnt_reg == LAST_BIT);
  assign data_ready = boundary && !train;
  assign accept     = data_ready && data_valid;

  // The shifter always emits its MSB first; LSB-first mode bit-reverses the word at load.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
      assign load_rev[gi] = load_word[DATA_WIDTH-1-gi];
    end
  endgenerate

  assign load_ordered = MSB_FIRST ? load_word : load_rev;

  // Load-source selection at the slot boundary: training beats data beats idle.
  always_comb begin
    load_word = '0;
    slot_next = slot_reg;
    if (boundary) begin
      if (train) begin
        load_word = TRAIN_PATTERN;
        slot_next = SLOT_TRAIN;
      end else if (data_valid) begin
        load_word = data_in;
        slot_next = SLOT_DATA;
      end else begin
        slot_next = SLOT_IDLE;
      end
    end
  end

  always_comb begin
    shift_src         = boundary ? load_ordered : shift_reg;
    sout_next         = shift_src[DATA_WIDTH-1];
    shift_next        = shift_src << 1;
    bit_cnt_next      = boundary ? '0 : bit_cnt_reg + CW'(1);
    frame_start_next  = boundary;
    word_is_data_next = (slot_next == SLOT_DATA);
    tx_word_cnt_next  = accept ? tx_word_cnt_reg + 16'd1 : tx_word_cnt_reg;
  end

  // Counter resets to the last bit so the first cycle after release is a boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_reg         <= SLOT_IDLE;
      bit_cnt_reg      <= LAST_BIT;
      shift_reg        <= '0;
      sout_reg         <= 1'b0;
      frame_start_reg  <= 1'b0;
      word_is_data_reg <= 1'b0;
      tx_word_cnt_reg  <= 16'd0;
    end else begin
      slot_reg         <= slot_next;
      bit_cnt_reg      <= bit_cnt_next;
      shift_reg        <= shift_next;
      sout_reg         <= sout_next;
      frame_start_reg  <= frame_start_next;
      word_is_data_reg <= word_is_data_next;
      tx_word_cnt_reg  <= tx_word_cnt_next;
    end
  end

  assign sout         = sout_reg;
  assign frame_start  = frame_start_reg;
  assign word_is_data = word_is_data_reg;
  assign tx_word_cnt  = tx_word_cnt_reg;

endmodule

// File: tb/tb_lvds_serializer_tx.sv
// Scoreboard bench for lvds_serializer_tx: the driver queues the expected serial
// stream per slot, a negedge monitor pops and compares it against both instances.
module tb_lvds_serializer_tx;

  typedef struct packed {
    logic        s;
    logic        fs;
    logic        wd;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        train;
  logic [9:0]  data_in;
  logic        data_valid;
  logic        ready_m, sout_m, fs_m, wd_m;
  logic [15:0] cnt_m;

  logic        train_l;
  logic [9:0]  data_l;
  logic        valid_l;
  logic        ready_l, sout_l, fs_l, wd_l;
  logic [15:0] cnt_l;

  exp_t        q_m[$];
  exp_t        q_l[$];
  logic [15:0] exp_cnt;
  logic [15:0] exp_cnt_l;
  int          n_cmp;
  int          n_bad;
  int          slot_no;

  lvds_serializer_tx #(.DATA_WIDTH(10), .TRAIN_PATTERN(10'h3F0), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .train(train), .data_in(data_in), .data_valid(data_valid),
    .data_ready(ready_m), .sout(sout_m), .frame_start(fs_m), .word_is_data(wd_m),
    .tx_word_cnt(cnt_m)
  );

  lvds_serializer_tx #(.DATA_WIDTH(10), .TRAIN_PATTERN(10'h3F0), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .train(train_l), .data_in(data_l), .data_valid(valid_l),
    .data_ready(ready_l), .sout(sout_l), .frame_start(fs_l), .word_is_data(wd_l),
    .tx_word_cnt(cnt_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: one expected entry per output cycle, stream order preserved by the queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (q_m.size() != 0) begin
          e = q_m.pop_front();
          chk("msb_stream {sout,fs,wd,cnt}", {13'd0, sout_m, fs_m, wd_m, cnt_m}, {13'd0, e});
        end
        if (q_l.size() != 0) begin
          e = q_l.pop_front();
          chk("lsb_stream {sout,fs,wd,cnt}", {13'd0, sout_l, fs_l, wd_l, cnt_l}, {13'd0, e});
        end
      end
    end
  end

  // Runs one full slot, entered at posedge+1 of a boundary cycle. exp_pat is the
  // hand-computed word in transmission order (bit 9 leaves first).
  task automatic slot(input bit tr, input bit tr_mid, input bit val, input logic [9:0] dat,
                      input bit late, input logic [9:0] exp_pat, input bit exp_wd,
                      input int rst_at, input bit preload, input bit lsb_go);
    exp_t e;
    slot_no++;
    $display("slot %0d: train=%0b valid=%0b late=%0b data=%h expected_bits=%b word_is_data=%0b",
             slot_no, tr, val, late, dat, exp_pat, exp_wd);
    train      = tr;
    data_valid = val && !late;
    data_in    = dat;
    if (lsb_go) begin
      valid_l = 1'b1;
      data_l  = 10'h001;
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 4) train = tr_mid;
      if (late && k == 1) data_valid = 1'b1;
      if (k == rst_at) begin
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset sout", {31'd0, sout_m}, 32'd0);
        chk("async_reset frame_start", {31'd0, fs_m}, 32'd0);
        chk("async_reset word_is_data", {31'd0, wd_m}, 32'd0);
        chk("async_reset tx_word_cnt", {16'd0, cnt_m}, 32'd0);
        chk("async_reset lsb tx_word_cnt", {16'd0, cnt_l}, 32'd0);
        q_m.delete();
        q_l.delete();
        exp_cnt   = 16'd0;
        exp_cnt_l = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        return;
      end
      @(negedge clk);
      chk($sformatf("data_ready slot%0d cyc%0d", slot_no, k), {31'd0, ready_m},
          {31'd0, (k == 0) && !tr});
      if (k == 0) begin
        #1;
        if (preload) exp_cnt = 16'hFFFF;
        if (val && !late && !tr) exp_cnt = exp_cnt + 16'd1;
        for (int j = 0; j < 10; j++) begin
          e.s   = exp_pat[9-j];
          e.fs  = (j == 0);
          e.wd  = exp_wd;
          e.cnt = exp_cnt;
          q_m.push_back(e);
        end
        if (lsb_go) begin
          chk("lsb data_ready at boundary", {31'd0, ready_l}, 32'd1);
          exp_cnt_l = exp_cnt_l + 16'd1;
          for (int j = 0; j < 10; j++) begin
            e.s   = (j == 0);
            e.fs  = (j == 0);
            e.wd  = 1'b1;
            e.cnt = exp_cnt_l;
            q_l.push_back(e);
          end
        end
        if (preload) begin
          #1;
          force dut_msb.tx_word_cnt_reg = 16'hFFFF;
          #1;
          release dut_msb.tx_word_cnt_reg;
        end
      end
      @(posedge clk);
      #1;
      if (k == 0 && lsb_go) valid_l = 1'b0;
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    slot_no    = 0;
    exp_cnt    = 16'd0;
    exp_cnt_l  = 16'd0;
    reset      = 1'b1;
    train      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;
    train_l    = 1'b0;
    data_l     = '0;
    valid_l    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sout", {31'd0, sout_m}, 32'd0);
    chk("reset frame_start", {31'd0, fs_m}, 32'd0);
    chk("reset word_is_data", {31'd0, wd_m}, 32'd0);
    chk("reset tx_word_cnt", {16'd0, cnt_m}, 32'd0);
    chk("reset lsb sout", {31'd0, sout_l}, 32'd0);
    reset = 1'b0;

    // Continuous stream, first boundary right after reset release.
    slot(0, 0, 1, 10'h2A5, 0, 10'b1010100101, 1, -1, 0, 0);
    slot(0, 0, 1, 10'h15A, 0, 10'b0101011010, 1, -1, 0, 0);
    // Training with data pending, then release mid-slot.
    slot(1, 1, 1, 10'h155, 0, 10'b1111110000, 0, -1, 0, 0);
    slot(1, 1, 1, 10'h155, 0, 10'b1111110000, 0, -1, 0, 0);
    slot(1, 0, 1, 10'h155, 0, 10'b1111110000, 0, -1, 0, 0);
    // Data loads; train raised mid-slot must not disturb this word.
    slot(0, 1, 1, 10'h155, 0, 10'b0101010101, 1, -1, 0, 0);
    slot(1, 0, 0, 10'h000, 0, 10'b1111110000, 0, -1, 0, 0);
    // Idle gaps then a single all-ones word.
    slot(0, 0, 0, 10'h000, 0, 10'b0000000000, 0, -1, 0, 0);
    slot(0, 0, 0, 10'h000, 0, 10'b0000000000, 0, -1, 0, 0);
    slot(0, 0, 1, 10'h3FF, 0, 10'b1111111111, 1, -1, 0, 0);
    // Late valid waits a whole slot.
    slot(0, 0, 1, 10'h0C3, 1, 10'b0000000000, 0, -1, 0, 0);
    slot(0, 0, 1, 10'h0C3, 0, 10'b0011000011, 1, -1, 0, 0);
    // LSB-first instance sends 10'h001 while the main instance idles.
    slot(0, 0, 0, 10'h000, 0, 10'b0000000000, 0, -1, 0, 1);
    // Counter wrap from a preloaded 16'hFFFF.
    slot(0, 0, 1, 10'h2A5, 0, 10'b1010100101, 1, -1, 1, 0);
    slot(0, 0, 1, 10'h15A, 0, 10'b0101011010, 1, -1, 0, 0);
    // Reset mid data word, then a fresh boundary immediately after release.
    slot(0, 0, 1, 10'h3FF, 0, 10'b1111111111, 1, 4, 0, 0);
    slot(0, 0, 1, 10'h2A5, 0, 10'b1010100101, 1, -1, 0, 0);
    slot(0, 0, 0, 10'h000, 0, 10'b0000000000, 0, -1, 0, 0);

    @(negedge clk);
    #1;
    chk("scoreboard drained", q_m.size() + q_l.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
